// File: rtl/decode_rf.sv
// decode_rf: decode stage with a stallable/flushable instruction register,
// field and immediate extraction, and the architectural integer register file
// with optional same-cycle writeback forwarding.
module decode_rf #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] I_PC,
    input  logic            INST_VALID,
    input  logic [31:0]     INST,
    input  logic            W_EN,
    input  logic [4:0]      W_REG,
    input  logic [XLEN-1:0] W_DATA,
    output logic            D_VALID,
    output logic [XLEN-1:0] D_PC,
    output logic [31:0]     D_INST,
    output logic [6:0]      OPCODE,
    output logic [2:0]      FUNCT3,
    output logic [6:0]      FUNCT7,
    output logic [XLEN-1:0] IMM,
    output logic [4:0]      REG_D,
    output logic [4:0]      REG_S1,
    output logic [4:0]      REG_S2,
    output logic [XLEN-1:0] REG_S1_V,
    output logic [XLEN-1:0] REG_S2_V,
    output logic            ILLEGAL
);

    localparam int unsigned RW       = 5;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic            d_valid_q;
    logic [XLEN-1:0] d_pc_q;
    logic [31:0]     d_inst_q;
    logic [XLEN-1:0] rf_q [1:NREG-1];

    logic            w_in, d_in, s1_in, s2_in;
    logic            w_hit;
    logic            op_ok;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] s1_v, s2_v;

    // Register-index range checks; an RV32E build rejects x16..x31
    if (NREG >= 32) begin : g_full
        assign w_in  = 1'b1;
        assign d_in  = 1'b1;
        assign s1_in = 1'b1;
        assign s2_in = 1'b1;
    end else begin : g_part
        assign w_in  = (W_REG          < RW'(NREG));
        assign d_in  = (d_inst_q[11:7]  < RW'(NREG));
        assign s1_in = (d_inst_q[19:15] < RW'(NREG));
        assign s2_in = (d_inst_q[24:20] < RW'(NREG));
    end

    assign w_hit = W_EN && (W_REG != '0) && w_in;

    // Instruction pipeline register: reset > flush > stall > load
    always_ff @(posedge CLK) begin
        if (RST) begin
            d_valid_q <= 1'b0;
            d_pc_q    <= '0;
            d_inst_q  <= NOP_INST;
        end else if (FLUSH) begin
            d_valid_q <= 1'b0;
        end else if (!STALL) begin
            d_valid_q <= INST_VALID;
            d_pc_q    <= I_PC;
            d_inst_q  <= INST;
        end
    end

    // Register file writeback, independent of stall/flush; x0 is not stored
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 1; i < NREG; i++) rf_q[i] <= '0;
        end else if (w_hit) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (W_REG == RW'(i)) rf_q[i] <= W_DATA;
            end
        end
    end

    // Operand read with optional forwarding of the in-flight writeback
    always_comb begin
        s1_v = '0;
        s2_v = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (d_inst_q[19:15] == RW'(i)) s1_v = rf_q[i];
            if (d_inst_q[24:20] == RW'(i)) s2_v = rf_q[i];
        end
        if (BYPASS && W_EN && s1_in && (d_inst_q[19:15] != '0) && (W_REG == d_inst_q[19:15]))
            s1_v = W_DATA;
        if (BYPASS && W_EN && s2_in && (d_inst_q[24:20] != '0) && (W_REG == d_inst_q[24:20]))
            s2_v = W_DATA;
    end

    // Immediate extraction by instruction format, sign-extended to XLEN
    always_comb begin
        imm   = '0;
        op_ok = 1'b1;
        case (d_inst_q[6:0])
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
                imm = XLEN'($signed(d_inst_q[31:20]));
            7'b0100011:
                imm = XLEN'($signed({d_inst_q[31:25], d_inst_q[11:7]}));
            7'b1100011:
                imm = XLEN'($signed({d_inst_q[31], d_inst_q[7], d_inst_q[30:25],
                                     d_inst_q[11:8], 1'b0}));
            7'b0110111, 7'b0010111:
                imm = XLEN'($signed({d_inst_q[31:12], 12'b0}));
            7'b1101111:
                imm = XLEN'($signed({d_inst_q[31], d_inst_q[19:12], d_inst_q[20],
                                     d_inst_q[30:21], 1'b0}));
            7'b0110011:
                imm = '0;
            default: begin
                imm   = '0;
                op_ok = 1'b0;
            end
        endcase
    end

    assign D_VALID  = d_valid_q;
    assign D_PC     = d_pc_q;
    assign D_INST   = d_inst_q;
    assign OPCODE   = d_inst_q[6:0];
    assign FUNCT3   = d_inst_q[14:12];
    assign FUNCT7   = d_inst_q[31:25];
    assign REG_D    = d_inst_q[11:7];
    assign REG_S1   = d_inst_q[19:15];
    assign REG_S2   = d_inst_q[24:20];
    assign IMM      = imm;
    assign REG_S1_V = s1_v;
    assign REG_S2_V = s2_v;
    assign ILLEGAL  = d_valid_q & (~op_ok | ~d_in | ~s1_in | ~s2_in);

endmodule

// File: tb/tb_decode_rf.sv
// Bench for decode_rf: three instances (RV32I bypass, RV32I no bypass, RV32E)
// share one stimulus stream and are checked against expected values.
module tb_decode_rf;

    logic        CLK, RST, STALL, FLUSH, INST_VALID, W_EN;
    logic [31:0] I_PC, INST, W_DATA;
    logic [4:0]  W_REG;

    logic        a_dv, n_dv, e_dv, a_ill, n_ill, e_ill;
    logic [31:0] a_pc, n_pc, e_pc, a_inst, n_inst, e_inst;
    logic [6:0]  a_op, n_op, e_op, a_f7, n_f7, e_f7;
    logic [2:0]  a_f3, n_f3, e_f3;
    logic [31:0] a_imm, n_imm, e_imm;
    logic [4:0]  a_rd, n_rd, e_rd, a_rs1, n_rs1, e_rs1, a_rs2, n_rs2, e_rs2;
    logic [31:0] a_s1v, n_s1v, e_s1v, a_s2v, n_s2v, e_s2v;

    int n_tests = 0;
    int n_fail  = 0;

    decode_rf #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .I_PC(I_PC),
        .INST_VALID(INST_VALID), .INST(INST), .W_EN(W_EN), .W_REG(W_REG), .W_DATA(W_DATA),
        .D_VALID(a_dv), .D_PC(a_pc), .D_INST(a_inst), .OPCODE(a_op), .FUNCT3(a_f3),
        .FUNCT7(a_f7), .IMM(a_imm), .REG_D(a_rd), .REG_S1(a_rs1), .REG_S2(a_rs2),
        .REG_S1_V(a_s1v), .REG_S2_V(a_s2v), .ILLEGAL(a_ill));

    decode_rf #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_n (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .I_PC(I_PC),
        .INST_VALID(INST_VALID), .INST(INST), .W_EN(W_EN), .W_REG(W_REG), .W_DATA(W_DATA),
        .D_VALID(n_dv), .D_PC(n_pc), .D_INST(n_inst), .OPCODE(n_op), .FUNCT3(n_f3),
        .FUNCT7(n_f7), .IMM(n_imm), .REG_D(n_rd), .REG_S1(n_rs1), .REG_S2(n_rs2),
        .REG_S1_V(n_s1v), .REG_S2_V(n_s2v), .ILLEGAL(n_ill));

    decode_rf #(.XLEN(32), .NREG(16), .BYPASS(1'b1)) dut_e (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .I_PC(I_PC),
        .INST_VALID(INST_VALID), .INST(INST), .W_EN(W_EN), .W_REG(W_REG), .W_DATA(W_DATA),
        .D_VALID(e_dv), .D_PC(e_pc), .D_INST(e_inst), .OPCODE(e_op), .FUNCT3(e_f3),
        .FUNCT7(e_f7), .IMM(e_imm), .REG_D(e_rd), .REG_S1(e_rs1), .REG_S2(e_rs2),
        .REG_S1_V(e_s1v), .REG_S2_V(e_s2v), .ILLEGAL(e_ill));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ill;
        logic        ill_e;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    initial begin
        vec_t v;

        //            inst          pc         vld  imm           op     f3    f7     rd  rs1 rs2 ill ill_e
        vecs[0] = '{32'hFFF00093, 32'h200, 1'b1, 32'hFFFFFFFF, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd31, 1'b0, 1'b1};
        vecs[1] = '{32'h7FF00093, 32'h204, 1'b1, 32'h000007FF, 7'h13, 3'd0, 7'h3F, 5'd1,  5'd0,  5'd31, 1'b0, 1'b1};
        vecs[2] = '{32'hFE112E23, 32'h208, 1'b1, 32'hFFFFFFFC, 7'h23, 3'd2, 7'h7F, 5'd28, 5'd2,  5'd1,  1'b0, 1'b1};
        vecs[3] = '{32'hFE000EE3, 32'h20C, 1'b1, 32'hFFFFFFFC, 7'h63, 3'd0, 7'h7F, 5'd29, 5'd0,  5'd0,  1'b0, 1'b1};
        vecs[4] = '{32'h123450B7, 32'h210, 1'b1, 32'h12345000, 7'h37, 3'd5, 7'h09, 5'd1,  5'd8,  5'd3,  1'b0, 1'b0};
        vecs[5] = '{32'hFFDFF06F, 32'h214, 1'b1, 32'hFFFFFFFC, 7'h6F, 3'd7, 7'h7F, 5'd0,  5'd31, 5'd29, 1'b0, 1'b1};
        vecs[6] = '{32'h002081B3, 32'h218, 1'b1, 32'h00000000, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2,  1'b0, 1'b0};
        vecs[7] = '{32'h002088B3, 32'h21C, 1'b1, 32'h00000000, 7'h33, 3'd0, 7'h00, 5'd17, 5'd1,  5'd2,  1'b0, 1'b1};
        vecs[8] = '{32'h0000007F, 32'h220, 1'b1, 32'h00000000, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
        vecs[9] = '{32'h0000007F, 32'h224, 1'b0, 32'h00000000, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0};

        RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; I_PC = '0; INST_VALID = 1'b0;
        INST = 32'h0000_0013; W_EN = 1'b0; W_REG = '0; W_DATA = '0;

        // Reset held two cycles
        tick(); tick();
        check("rst_dvalid", 64'(a_dv), 64'h0);
        check("rst_pc", 64'(a_pc), 64'h0);
        check("rst_inst", 64'(a_inst), 64'h13);
        check("rst_opcode", 64'(a_op), 64'h13);
        check("rst_imm", 64'(a_imm), 64'h0);
        check("rst_s1v", 64'(a_s1v), 64'h0);
        check("rst_ill_e", 64'(e_ill), 64'h0);
        RST = 1'b0;

        // All architectural registers read zero after reset
        for (int i = 1; i < 32; i++) begin
            INST = mk_r(5'd0, 5'(i), 5'(i)); INST_VALID = 1'b1;
            tick();
            check("idle_read_a", 64'(a_s1v), 64'h0);
            check("idle_read_n", 64'(n_s2v), 64'h0);
            check("idle_read_e", 64'(e_s1v), 64'h0);
        end

        // Decode table through the scoreboard
        for (int k = 0; k < 10; k++) begin
            INST = vecs[k].inst; I_PC = vecs[k].pc; INST_VALID = vecs[k].valid;
            sb_q.push_back(vecs[k]);
            tick();
            v = sb_q.pop_front();
            check("vec_dvalid", 64'(a_dv), 64'(v.valid));
            check("vec_pc", 64'(a_pc), 64'(v.pc));
            check("vec_inst", 64'(a_inst), 64'(v.inst));
            check("vec_opcode", 64'(a_op), 64'(v.op));
            check("vec_funct3", 64'(a_f3), 64'(v.f3));
            check("vec_funct7", 64'(a_f7), 64'(v.f7));
            check("vec_imm", 64'(a_imm), 64'(v.imm));
            check("vec_rd", 64'(a_rd), 64'(v.rd));
            check("vec_rs1", 64'(a_rs1), 64'(v.rs1));
            check("vec_rs2", 64'(a_rs2), 64'(v.rs2));
            check("vec_ill", 64'(a_ill), 64'(v.ill));
            check("vec_ill_n", 64'(n_ill), 64'(v.ill));
            check("vec_ill_e", 64'(e_ill), 64'(v.ill_e));
            check("vec_n_fields", {n_dv, n_pc, n_op, n_f3, n_f7, n_rd, n_rs1, n_rs2},
                  {v.valid, v.pc, v.op, v.f3, v.f7, v.rd, v.rs1, v.rs2});
            check("vec_e_fields", {e_dv, e_pc, e_op, e_f3, e_f7, e_rd, e_rs1, e_rs2},
                  {v.valid, v.pc, v.op, v.f3, v.f7, v.rd, v.rs1, v.rs2});
            check("vec_imm_ne", {n_imm, e_imm}, {v.imm, v.imm});
            check("vec_inst_ne", {n_inst, e_inst}, {v.inst, v.inst});
            check("vec_ops_zero", {a_s1v, a_s2v}, 64'h0);
        end

        // Writeback forwarding: rs1 == rs2 == W_REG == x5
        INST = mk_r(5'd0, 5'd5, 5'd5); INST_VALID = 1'b1; I_PC = 32'h300;
        tick();
        W_EN = 1'b1; W_REG = 5'd5; W_DATA = 32'hDEADBEEF;
        #1;
        check("byp_s1_a", 64'(a_s1v), 64'hDEADBEEF);
        check("byp_s2_a", 64'(a_s2v), 64'hDEADBEEF);
        check("byp_s1_n", 64'(n_s1v), 64'h0);
        check("byp_s2_n", 64'(n_s2v), 64'h0);
        check("byp_s1_e", 64'(e_s1v), 64'hDEADBEEF);
        tick();
        W_EN = 1'b0;
        #1;
        check("wb_s1_n", 64'(n_s1v), 64'hDEADBEEF);
        check("wb_s2_n", 64'(n_s2v), 64'hDEADBEEF);
        check("wb_s1_a", 64'(a_s1v), 64'hDEADBEEF);
        check("wb_s2_e", 64'(e_s2v), 64'hDEADBEEF);

        // x0 write is discarded and never forwarded
        INST = mk_r(5'd0, 5'd0, 5'd0);
        tick();
        W_EN = 1'b1; W_REG = 5'd0; W_DATA = 32'hFFFFFFFF;
        #1;
        check("x0_byp", 64'(a_s1v), 64'h0);
        tick();
        W_EN = 1'b0;
        #1;
        check("x0_after", 64'(a_s1v), 64'h0);
        check("x0_after_n", 64'(n_s2v), 64'h0);

        // x17: legal on RV32I, out of range on RV32E
        INST = mk_r(5'd0, 5'd17, 5'd17);
        tick();
        check("x17_ill_e", 64'(e_ill), 64'h1);
        check("x17_ill_a", 64'(a_ill), 64'h0);
        W_EN = 1'b1; W_REG = 5'd17; W_DATA = 32'h12345678;
        #1;
        check("x17_byp_a", 64'(a_s1v), 64'h12345678);
        check("x17_byp_e", 64'(e_s1v), 64'h0);
        tick();
        W_EN = 1'b0;
        #1;
        check("x17_rd_a", 64'(a_s1v), 64'h12345678);
        check("x17_rd_e", 64'(e_s2v), 64'h0);
        INST = mk_r(5'd0, 5'd1, 5'd1);
        tick();
        check("x17_alias_e", 64'(e_s1v), 64'h0);
        check("x1_clean_a", 64'(a_s1v), 64'h0);

        // Stall holds the register while writeback continues; flush beats stall
        I_PC = 32'h100; INST = mk_r(5'd9, 5'd7, 5'd7); INST_VALID = 1'b1;
        tick();
        check("ld_pc", 64'(a_pc), 64'h100);
        check("ld_valid", 64'(a_dv), 64'h1);
        STALL = 1'b1; I_PC = 32'h104; INST = mk_r(5'd10, 5'd8, 5'd8);
        W_EN = 1'b1; W_REG = 5'd7; W_DATA = 32'hA5A5A5A5;
        tick();
        W_EN = 1'b0;
        #1;
        check("stall_pc", 64'(a_pc), 64'h100);
        check("stall_inst", 64'(a_inst), 64'(mk_r(5'd9, 5'd7, 5'd7)));
        check("stall_valid", 64'(a_dv), 64'h1);
        check("stall_wr_n", 64'(n_s1v), 64'hA5A5A5A5);
        FLUSH = 1'b1;
        tick();
        check("flush_valid", 64'(a_dv), 64'h0);
        check("flush_pc", 64'(a_pc), 64'h100);
        check("flush_inst", 64'(n_inst), 64'(mk_r(5'd9, 5'd7, 5'd7)));
        FLUSH = 1'b0; STALL = 1'b0;
        tick();
        check("resume_pc", 64'(a_pc), 64'h104);
        check("resume_valid", 64'(a_dv), 64'h1);
        check("resume_inst", 64'(a_inst), 64'(mk_r(5'd10, 5'd8, 5'd8)));

        // Reset mid-operation wins over stall and drops the write
        INST = mk_r(5'd0, 5'd3, 5'd3);
        W_EN = 1'b1; W_REG = 5'd3; W_DATA = 32'h33;
        tick();
        W_EN = 1'b0;
        #1;
        check("x3_set", 64'(n_s1v), 64'h33);
        RST = 1'b1; STALL = 1'b1; W_EN = 1'b1; W_REG = 5'd3; W_DATA = 32'h99;
        tick();
        RST = 1'b0; STALL = 1'b0; W_EN = 1'b0;
        #1;
        check("mrst_valid", 64'(a_dv), 64'h0);
        check("mrst_inst", 64'(a_inst), 64'h13);
        check("mrst_pc", 64'(a_pc), 64'h0);
        INST = mk_r(5'd0, 5'd3, 5'd3);
        tick();
        check("mrst_x3_a", 64'(a_s1v), 64'h0);
        check("mrst_x3_n", 64'(n_s1v), 64'h0);
        check("mrst_x5_n", 64'(n_s2v), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
